// File: rtl/trinity_mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH core channels onto a single memory port.
// Optional feature: define TRINITY_MEM_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYC cycles.
module trinity_mem_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_we,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_exception,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        addr,
   output logic [DATA_W-1:0]        wdata,
   input  logic [DATA_W-1:0]        rdata,
   input  logic                     mem_ack,
   output logic                     busy
);

   // state   | meaning
   // IDLE    | no transaction; arbitrate among ch_req from rr_ptr
   // BUSY    | mem_req held with latched we/addr/wdata, waiting for mem_ack
   // RESP    | one-cycle ch_ack (and ch_exception on timeout) to granted channel

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_check
      $error("trinity_mem_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    gnt_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NUM_CH-1:0]   ch_ack_q;
   logic [DATA_W-1:0]   ch_rdata_q;
   logic                busy_q;

   logic [IDX_W-1:0]    gnt_d;
   logic                gnt_vld_d;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [NUM_CH-1:0]   gnt_oh;
   logic [IDX_W-1:0]    rr_ptr_d;

`ifdef TRINITY_MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0]          to_cnt_q;
   logic [NUM_CH-1:0]   ch_exc_q;
`endif

   // Walk offsets from the far end inward so the nearest requester at or after rr_ptr wins.
   always_comb begin
      gnt_vld_d = 1'b0;
      gnt_d     = rr_ptr_q;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_req[i] &&
                ((int'(rr_ptr_q) + k == i) || (int'(rr_ptr_q) + k == i + NUM_CH))) begin
               gnt_vld_d = 1'b1;
               gnt_d     = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_d == IDX_W'(i)) begin
            sel_we    = ch_we[i];
            sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign gnt_oh   = NUM_CH'(1) << gnt_q;
   assign rr_ptr_d = (gnt_q == IDX_W'(NUM_CH - 1)) ? '0 : gnt_q + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ch_ack_q   <= '0;
         ch_rdata_q <= '0;
         busy_q     <= 1'b0;
`ifdef TRINITY_MEM_TIMEOUT_EN
         to_cnt_q   <= '0;
         ch_exc_q   <= '0;
`endif
      end else begin
         ch_ack_q <= '0;
`ifdef TRINITY_MEM_TIMEOUT_EN
         ch_exc_q <= '0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (gnt_vld_d) begin
                  gnt_q     <= gnt_d;
                  mem_we_q  <= sel_we;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_BUSY;
`ifdef TRINITY_MEM_TIMEOUT_EN
                  to_cnt_q  <= '0;
`endif
               end
            end
            ST_BUSY: begin
               // A mem_ack in the timeout cycle still counts as a normal completion.
               if (mem_ack) begin
                  ch_rdata_q <= mem_we_q ? '0 : rdata;
                  mem_req_q  <= 1'b0;
                  ch_ack_q   <= gnt_oh;
                  state_q    <= ST_RESP;
               end
`ifdef TRINITY_MEM_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  ch_rdata_q <= '0;
                  mem_req_q  <= 1'b0;
                  ch_ack_q   <= gnt_oh;
                  ch_exc_q   <= gnt_oh;
                  state_q    <= ST_RESP;
               end else begin
                  to_cnt_q   <= to_cnt_q + 8'd1;
               end
`endif
            end
            ST_RESP: begin
               rr_ptr_q <= rr_ptr_d;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ch_ack   = ch_ack_q;
   assign ch_rdata = ch_rdata_q;
   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign addr     = addr_q;
   assign wdata    = wdata_q;
   assign busy     = busy_q;

`ifdef TRINITY_MEM_TIMEOUT_EN
   assign ch_exception = ch_exc_q;
`else
   assign ch_exception = '0;
`endif

endmodule

// File: tb/tb_trinity_mem_arbiter.sv
// Bench for trinity_mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level round-robin model.
module tb_trinity_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;
`ifdef TRINITY_MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  ch_req = '0;
   logic [N-1:0]  ch_we = '0;
   logic [N*AW-1:0] ch_addr = '0;
   logic [N*DW-1:0] ch_wdata = '0;
   logic [N-1:0]  ch_ack;
   logic [N-1:0]  ch_exception;
   logic [DW-1:0] ch_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata = '0;
   logic          mem_ack = 1'b0;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   // transaction-level reference: who owns the port, whether its answer is due
   int          m_ptr   = 0;
   int          m_owner = -1;
   int          m_wait  = 0;
   bit          m_done  = 1'b0;
   bit          m_exc   = 1'b0;
   bit          m_we    = 1'b0;
   logic [63:0] m_addr  = '0;
   logic [63:0] m_wd    = '0;
   logic [63:0] m_rd    = '0;

   int lat = 0;
   int order[$];

   trinity_mem_arbiter #(
      .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
      .ch_ack(ch_ack), .ch_exception(ch_exception), .ch_rdata(ch_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] req, input int ptr);
      for (int o = 0; o < N; o++)
         if (req[(ptr + o) % N]) return (ptr + o) % N;
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ch_ack"}, ch_ack, 0);
      check({tag, "_ch_exc"}, ch_exception, 0);
      check({tag, "_ch_rdata"}, ch_rdata, 0);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_zero("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst_hold");
      rst     = 1'b0;
      m_ptr   = 0;
      m_owner = -1;
      m_done  = 1'b0;
      m_exc   = 1'b0;
      m_wait  = 0;
      m_rd    = '0;
   endtask

   // Advance the model on the inputs present now, take one clock edge, compare.
   task automatic tick();
      logic [N-1:0] oh;
      if (m_owner < 0) begin
         if (ch_req != '0) begin
            m_owner = pick(ch_req, m_ptr);
            m_we    = ch_we[m_owner];
            m_addr  = ch_addr[m_owner*AW +: AW];
            m_wd    = ch_wdata[m_owner*DW +: DW];
            m_done  = 1'b0;
            m_exc   = 1'b0;
            m_wait  = 0;
         end
      end else if (!m_done) begin
         if (mem_ack) begin
            m_done = 1'b1;
            m_rd   = m_we ? '0 : rdata;
         end else begin
            m_wait++;
            if (TO_EN && m_wait >= TO) begin
               m_done = 1'b1;
               m_exc  = 1'b1;
               m_rd   = '0;
            end
         end
      end else begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
         m_done  = 1'b0;
         m_exc   = 1'b0;
      end
      @(posedge clk);
      #1;
      oh = '0;
      if (m_owner >= 0 && m_done) oh[m_owner] = 1'b1;
      check("busy", busy, m_owner >= 0);
      check("mem_req", mem_req, m_owner >= 0 && !m_done);
      if (m_owner >= 0 && !m_done) begin
         check("mem_we", mem_we, m_we);
         check("addr", addr, m_addr);
         check("wdata", wdata, m_wd);
      end
      check("ch_ack", ch_ack, oh);
      check("ch_exception", ch_exception, m_exc ? oh : '0);
      check("ch_rdata", ch_rdata, m_rd);
   endtask

   initial begin
      int n;
      int idle_n;
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      #2;
      do_reset();

      // single read
      ch_addr[0 +: AW] = 64'h100;
      ch_we  = 4'b0000;
      ch_req = 4'b0001;
      tick();
      check("rd_addr", addr, 64'h100);
      check("rd_mem_req", mem_req, 1);
      mem_ack = 1'b1;
      rdata   = 64'hDEAD;
      tick();
      check("rd_ch_ack", ch_ack, 4'b0001);
      check("rd_ch_rdata", ch_rdata, 64'hDEAD);
      ch_req  = '0;
      mem_ack = 1'b0;
      rdata   = 64'h0;
      tick();
      tick();
      check("rd_hold", ch_rdata, 64'hDEAD);

      // contention with immediate acks from reset pointer
      do_reset();
      ch_req = 4'b1111;
      idle_n = 0;
      order.delete();
      for (int c = 0; c < 15; c++) begin
         mem_ack = mem_req;
         rdata   = {$urandom, $urandom};
         tick();
         if (busy === 1'b0) idle_n++;
         for (int i = 0; i < N; i++)
            if (ch_ack[i] === 1'b1) order.push_back(i);
      end
      ch_req  = '0;
      mem_ack = 1'b0;
      check("rr_grants", order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         check("rr_order", order[i], exp_ord[i]);
      check("rr_idle_gaps", idle_n, 5);
      tick();

      // write with delayed ack
      ch_we  = 4'b0100;
      ch_addr[2*AW +: AW]  = 64'h200;
      ch_wdata[2*DW +: DW] = 64'h1234;
      ch_req = 4'b0100;
      tick();
      n = 0;
      for (int c = 0; c < 20 && mem_req === 1'b1; c++) begin
         n++;
         check("wr_addr", addr, 64'h200);
         check("wr_wdata", wdata, 64'h1234);
         check("wr_mem_we", mem_we, 1);
         if (n == 6) begin
            mem_ack = 1'b1;
            rdata   = 64'hBEEF;
         end
         tick();
      end
      check("wr_hold_cycles", n, 6);
      check("wr_ch_ack", ch_ack, 4'b0100);
      check("wr_ch_rdata", ch_rdata, 0);
      ch_req  = '0;
      ch_we   = '0;
      mem_ack = 1'b0;
      tick();

`ifdef TRINITY_MEM_TIMEOUT_EN
      // stalled access times out
      ch_req = 4'b0010;
      tick();
      n = 0;
      for (int c = 0; c < 30 && mem_req === 1'b1; c++) begin
         n++;
         tick();
      end
      check("to_cycles", n, TO);
      check("to_ch_ack", ch_ack, 4'b0010);
      check("to_ch_exc", ch_exception, 4'b0010);
      check("to_ch_rdata", ch_rdata, 0);
      ch_req  = '0;
      mem_ack = 1'b1;
      tick();
      tick();
      tick();
      check("late_ack_mem_req", mem_req, 0);
      check("late_ack_busy", busy, 0);
      mem_ack = 1'b0;

      // ack on the timeout cycle completes normally
      ch_req = 4'b0010;
      tick();
      n = 0;
      for (int c = 0; c < 30 && mem_req === 1'b1; c++) begin
         n++;
         if (n == TO) begin
            mem_ack = 1'b1;
            rdata   = 64'h5A5A;
         end
         tick();
      end
      check("to_race_cycles", n, TO);
      check("to_race_ack", ch_ack, 4'b0010);
      check("to_race_exc", ch_exception, 0);
      check("to_race_rdata", ch_rdata, 64'h5A5A);
      ch_req  = '0;
      mem_ack = 1'b0;
      tick();
`endif

      // reset while channel 3 is in flight
      ch_addr[3*AW +: AW] = 64'h300;
      ch_req = 4'b1000;
      tick();
      check("mid_addr", addr, 64'h300);
      tick();
      ch_addr[0 +: AW] = 64'h400;
      ch_req = 4'b1001;
      do_reset();
      tick();
      check("post_rst_addr", addr, 64'h400);
      check("post_rst_mem_req", mem_req, 1);
      mem_ack = 1'b1;
      rdata   = 64'h77;
      tick();
      check("post_rst_ack", ch_ack, 4'b0001);
      ch_req  = '0;
      mem_ack = 1'b0;
      tick();

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (ch_ack[i] === 1'b1) begin
               ch_req[i] = 1'b0;
            end else if (!ch_req[i] && $urandom_range(0, 3) == 0) begin
               ch_req[i] = 1'b1;
               ch_we[i]  = $urandom_range(0, 1);
               ch_addr[i*AW +: AW]  = {$urandom, $urandom};
               ch_wdata[i*DW +: DW] = {$urandom, $urandom};
            end
         end
         if (m_owner >= 0 && !m_done && $urandom_range(0, 15) == 0)
            ch_req[m_owner] = 1'b0;
         rdata = {$urandom, $urandom};
         if (mem_req === 1'b1) begin
            if (lat == 0) begin
               mem_ack = 1'b1;
            end else begin
               lat--;
               mem_ack = 1'b0;
            end
         end else begin
            mem_ack = $urandom_range(0, 1);
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trinity_mem_arbiter.md
TRINITY_MEM_ARBITER -- requirements
Module: trinity_mem_arbiter

Interface
Parameters:
REQ-001 NUM_CH, default 4: number of requesting core channels, range 2..16.
REQ-002 ADDR_W, default 64: address width in bits.
REQ-003 DATA_W, default 64: data width in bits.
REQ-004 TIMEOUT_CYC, default 16: cycles to wait for mem_ack before abort, range 2..255.

Ports:
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 ch_req  in  NUM_CH  per-channel request, held until ch_ack.
REQ-009 ch_we  in  NUM_CH  per-channel write enable.
REQ-010 ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i.
REQ-011 ch_wdata  in  NUM_CH*DATA_W  per-channel write data.
REQ-012 ch_ack  out  NUM_CH  one-hot, one-cycle completion pulse.
REQ-013 ch_exception  out  NUM_CH  one-hot timeout flag, pulsed with ch_ack.
REQ-014 ch_rdata  out  DATA_W  read data, valid while any ch_ack bit is high.
REQ-015 mem_req  out  1  downstream request.
REQ-016 mem_we  out  1  downstream write enable.
REQ-017 addr  out  ADDR_W  downstream address.
REQ-018 wdata  out  DATA_W  downstream write data.
REQ-019 rdata  in  DATA_W  downstream read data, valid with mem_ack.
REQ-020 mem_ack  in  1  downstream acknowledge.
REQ-021 busy  out  1  high in every state other than IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-023 In IDLE, when any ch_req bit is high, the block SHALL grant the first requesting channel at or after rr_ptr (modulo NUM_CH).
REQ-024 On grant, the block SHALL register mem_we, addr and wdata from the granted channel, set mem_req=1 and move to BUSY at the next edge.
REQ-025 In BUSY, mem_req, mem_we, addr and wdata SHALL stay stable until the cycle in which mem_ack is sampled high.
REQ-026 When mem_ack is sampled high in BUSY, the block SHALL capture rdata into ch_rdata, clear mem_req and move to RESP.
REQ-027 In RESP, ch_ack[g] SHALL be high for exactly one cycle; the state then returns to IDLE and rr_ptr = (g+1) mod NUM_CH.
REQ-028 Minimum latency SHALL be: request seen in cycle 0, mem_req in cycle 1, mem_ack in cycle 1, ch_ack in cycle 2; each grant occupies at least 3 cycles.
REQ-029 mem_ack sampled in IDLE or RESP SHALL be ignored.
REQ-030 The granted channel dropping ch_req before ch_ack SHALL NOT abort the transaction; it completes normally.
REQ-031 Simultaneous requests SHALL each receive exactly one grant per arbitration round; no channel SHALL starve while it holds ch_req.
REQ-032 ch_rdata SHALL hold its last value outside RESP; it SHALL be 0 for writes and for timeouts.

Reset
REQ-033 While rst is high, the block SHALL be in IDLE with rr_ptr=0 and all outputs 0 (ch_ack, ch_exception, ch_rdata, mem_req, mem_we, addr, wdata, busy).
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no ch_ack; mem_req SHALL fall asynchronously.
REQ-035 The first grant after reset release SHALL be evaluated on the first rising edge with rst low.

Configuration
REQ-036 With TRINITY_MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-037 With TRINITY_MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the block SHALL clear mem_req and enter RESP, pulsing ch_ack[g] and ch_exception[g] with ch_rdata=0.
REQ-038 With TRINITY_MEM_TIMEOUT_EN defined, mem_ack arriving in the same cycle as the timeout SHALL take priority as a normal completion.
REQ-039 Without TRINITY_MEM_TIMEOUT_EN, no counter SHALL be instantiated, BUSY SHALL wait indefinitely and ch_exception SHALL be tied to 0.

Verification (NUM_CH=4, TIMEOUT_CYC=8)
REQ-040 Single read: ch_req=0001, ch_addr[0]=0x100, mem_ack one cycle after mem_req with rdata=0xDEAD -> addr=0x100, ch_ack=0001 two cycles after request, ch_rdata=0xDEAD.
REQ-041 Contention: ch_req=1111 held, immediate acks -> grant order 0,1,2,3,0; every ch_ack pulse is one cycle long; busy is low for one cycle between grants.
REQ-042 Write hold: ch_req=0100, ch_we=0100, wdata=0x1234, mem_ack delayed 5 cycles -> mem_req, mem_we, addr and wdata stable for 6 cycles; ch_ack=0100; ch_rdata=0.
REQ-043 Timeout (macro on): ch_req=0010, no mem_ack -> mem_req falls after 8 BUSY cycles; ch_ack=0010 and ch_exception=0010 together; a late mem_ack in IDLE has no effect.
REQ-044 Reset mid-BUSY: rst pulsed during BUSY on channel 3 -> all outputs 0 immediately; no ch_ack; the next grant with ch_req=1001 goes to channel 0.
